// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage program counter with stall, flush/replay,
// branch redirect, exception entry and a RUN/HALT state machine.
// Optional return-address stack for call/return prediction, compiled in
// when the macro PC_SEQ_RAS_EN is defined.
module pc_sequencer #(
  parameter int unsigned      WIDTH        = 32,
  parameter int unsigned      STEP         = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h0000_0080),
  parameter int unsigned      RAS_DEPTH    = 4
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_target,
  input  logic             call,
  input  logic             ret,
  input  logic             exc,
  input  logic             halt,
  input  logic             resume,
  output logic [WIDTH-1:0] PCResult,
  output logic             halted,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_underflow
);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_next;
  logic [WIDTH-1:0] pc_plus;
  logic             halt_req;
  logic             ras_clear;

  assign pc_plus = pc + STEP_W;

`ifdef PC_SEQ_RAS_EN
  localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [PTR_W:0] COUNT_FULL = (PTR_W+1)'(RAS_DEPTH);
  localparam logic [PTR_W:0] COUNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  // ras_ptr points at the next free slot; the top lives one below it.
  // Pushing when full simply walks over the oldest entry.
  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] ras_ptr;
  logic [PTR_W-1:0] top_idx;
  logic [PTR_W:0]   ras_count;
  logic [WIDTH-1:0] ras_top;
  logic             underflow_q;
  logic             push_req;
  logic             ras_push;
  logic             ras_pop;
  logic             ras_replace;
  logic             set_underflow;

  assign top_idx  = ras_ptr - PTR_ONE;
  assign ras_top  = ras_mem[top_idx];
  assign push_req = call & redirect_valid;
`else
  logic unused_call;
  localparam int unsigned unused_ras_depth = RAS_DEPTH;
  assign unused_call = call;
`endif

  // Next PC and stack operations, resolved in strict priority order.
  always_comb begin
    pc_next   = pc;
    halt_req  = 1'b0;
    ras_clear = 1'b0;
`ifdef PC_SEQ_RAS_EN
    ras_push      = 1'b0;
    ras_pop       = 1'b0;
    ras_replace   = 1'b0;
    set_underflow = 1'b0;
`endif
    if (exc) begin
      pc_next   = EXC_VECTOR;
      ras_clear = 1'b1;
    end else if (state == HALT) begin
      pc_next = pc;
    end else if (ret) begin
`ifdef PC_SEQ_RAS_EN
      if (ras_count == '0) begin
        pc_next       = redirect_target;
        set_underflow = 1'b1;
        ras_push      = push_req;
      end else begin
        pc_next     = ras_top;
        ras_replace = push_req;
        ras_pop     = ~push_req;
      end
`else
      pc_next = redirect_target;
`endif
    end else if (redirect_valid) begin
      pc_next = redirect_target;
`ifdef PC_SEQ_RAS_EN
      ras_push = push_req;
`endif
    end else if (flush) begin
      pc_next = pc - STEP_W;
    end else if (halt) begin
      halt_req = 1'b1;
    end else if (stall) begin
      pc_next = pc;
    end else begin
      pc_next = pc_plus;
    end
  end

  // State and PC registers; reset forces the fetch address to the vector.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= RUN;
      pc    <= RESET_VECTOR;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  // RUN/HALT transitions; exception entry always lands in RUN.
  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (halt_req) state_next = HALT;
      HALT:    if (exc || resume) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

`ifdef PC_SEQ_RAS_EN
  // Stack depth, pointer and sticky underflow flag.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      ras_ptr     <= '0;
      ras_count   <= '0;
      underflow_q <= 1'b0;
    end else if (ras_clear) begin
      ras_ptr     <= '0;
      ras_count   <= '0;
      underflow_q <= 1'b0;
    end else begin
      if (set_underflow) underflow_q <= 1'b1;
      if (ras_push) begin
        ras_ptr <= ras_ptr + PTR_ONE;
        if (ras_count != COUNT_FULL) ras_count <= ras_count + COUNT_ONE;
      end else if (ras_pop) begin
        ras_ptr   <= top_idx;
        ras_count <= ras_count - COUNT_ONE;
      end
    end
  end

  // Stack storage; entries beyond the depth count are never read.
  always_ff @(posedge Clk) begin
    if (ras_push) ras_mem[ras_ptr] <= pc_plus;
    else if (ras_replace) ras_mem[top_idx] <= pc_plus;
  end
`endif

  // Outputs decoded from registered state.
  always_comb begin
    PCResult = pc;
    halted   = (state == HALT);
`ifdef PC_SEQ_RAS_EN
    ras_empty     = (ras_count == '0);
    ras_full      = (ras_count == COUNT_FULL);
    ras_underflow = underflow_q;
`else
    ras_empty     = 1'b1;
    ras_full      = 1'b0;
    ras_underflow = 1'b0;
`endif
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer (32-bit default instance plus an
// 8-bit instance for wrap-around). Expectations follow PC_SEQ_RAS_EN.
module tb_pc_sequencer;

  logic        Clk;
  logic        Rst;
  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        call;
  logic        ret;
  logic        exc;
  logic        halt;
  logic        resume;
  logic [31:0] PCResult;
  logic        halted;
  logic        ras_empty;
  logic        ras_full;
  logic        ras_underflow;

  logic        rst8;
  logic        flush8;
  logic        zero8;
  logic [7:0]  target8;
  logic [7:0]  pc8;
  logic        halted8;
  logic        ras_empty8;
  logic        ras_full8;
  logic        ras_underflow8;

  int checks = 0;
  int errors = 0;

  pc_sequencer dut (
    .Clk(Clk), .Rst(Rst), .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .call(call), .ret(ret), .exc(exc), .halt(halt), .resume(resume),
    .PCResult(PCResult), .halted(halted), .ras_empty(ras_empty),
    .ras_full(ras_full), .ras_underflow(ras_underflow)
  );

  pc_sequencer #(.WIDTH(8), .STEP(4), .RESET_VECTOR(8'hFC), .EXC_VECTOR(8'h80), .RAS_DEPTH(4)) dut8 (
    .Clk(Clk), .Rst(rst8), .stall(zero8), .flush(flush8),
    .redirect_valid(zero8), .redirect_target(target8),
    .call(zero8), .ret(zero8), .exc(zero8), .halt(zero8), .resume(zero8),
    .PCResult(pc8), .halted(halted8), .ras_empty(ras_empty8),
    .ras_full(ras_full8), .ras_underflow(ras_underflow8)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic clear_inputs();
    stall = 0; flush = 0; redirect_valid = 0; redirect_target = '0;
    call = 0; ret = 0; exc = 0; halt = 0; resume = 0;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic rv, input logic [31:0] tgt, input logic c, input logic r);
    clear_inputs();
    redirect_valid = rv; redirect_target = tgt; call = c; ret = r;
    tick();
  endtask

  logic [31:0] exp_ret [5];

  initial begin
    clear_inputs();
    zero8 = 0; target8 = '0; flush8 = 0; rst8 = 1;
    Rst = 1;
    #2;
    check_output("reset_pc", PCResult, 32'h0);
    check_output("reset_halted", {31'b0, halted}, 32'h0);
    check_output("reset_empty", {31'b0, ras_empty}, 32'h1);
    check_output("reset_full", {31'b0, ras_full}, 32'h0);
    check_output("reset_underflow", {31'b0, ras_underflow}, 32'h0);
    check_output("reset_pc8", {24'b0, pc8}, 32'hFC);
    #1 Rst = 0;

    tick(); check_output("run_1", PCResult, 32'h4);
    tick(); check_output("run_2", PCResult, 32'h8);
    tick(); check_output("run_3", PCResult, 32'hC);

    Rst = 1;
    #1 check_output("async_reset", PCResult, 32'h0);
    Rst = 0;
    tick(); check_output("after_reset", PCResult, 32'h4);
    tick(); tick(); tick();
    check_output("reach_0x10", PCResult, 32'h10);

    clear_inputs(); stall = 1;
    tick(); check_output("stall_1", PCResult, 32'h10);
    tick(); check_output("stall_2", PCResult, 32'h10);
    clear_inputs(); flush = 1;
    tick(); check_output("flush", PCResult, 32'hC);
    clear_inputs(); flush = 1; stall = 1;
    tick(); check_output("flush_over_stall", PCResult, 32'h8);

    apply_stimulus(1, 32'h20, 0, 0);
    check_output("redirect", PCResult, 32'h20);
    apply_stimulus(1, 32'h100, 1, 0);
    check_output("call_target", PCResult, 32'h100);
`ifdef PC_SEQ_RAS_EN
    check_output("call_not_empty", {31'b0, ras_empty}, 32'h0);
`else
    check_output("call_empty_stub", {31'b0, ras_empty}, 32'h1);
`endif
    clear_inputs(); tick(); tick();
    check_output("reach_0x108", PCResult, 32'h108);
    apply_stimulus(0, 32'h500, 0, 1);
`ifdef PC_SEQ_RAS_EN
    check_output("ret_pop", PCResult, 32'h24);
`else
    check_output("ret_as_redirect", PCResult, 32'h500);
`endif
    check_output("ret_empty", {31'b0, ras_empty}, 32'h1);

    apply_stimulus(1, 32'h0, 0, 0);
    for (int i = 1; i <= 5; i++) apply_stimulus(1, 32'(i * 4), 1, 0);
    check_output("five_calls_pc", PCResult, 32'h14);
`ifdef PC_SEQ_RAS_EN
    check_output("ras_full", {31'b0, ras_full}, 32'h1);
    exp_ret[0] = 32'h14; exp_ret[1] = 32'h10; exp_ret[2] = 32'hC;
    exp_ret[3] = 32'h8;  exp_ret[4] = 32'h300;
`else
    check_output("ras_full_stub", {31'b0, ras_full}, 32'h0);
    for (int i = 0; i < 5; i++) exp_ret[i] = 32'h300;
`endif
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(0, 32'h300, 0, 1);
      check_output($sformatf("ret_%0d", i), PCResult, exp_ret[i]);
    end
`ifdef PC_SEQ_RAS_EN
    check_output("underflow_set", {31'b0, ras_underflow}, 32'h1);
`else
    check_output("underflow_stub", {31'b0, ras_underflow}, 32'h0);
`endif
    check_output("empty_after_rets", {31'b0, ras_empty}, 32'h1);

    apply_stimulus(1, 32'h400, 1, 0);
    check_output("call_0x400", PCResult, 32'h400);
    apply_stimulus(1, 32'h600, 1, 1);
`ifdef PC_SEQ_RAS_EN
    check_output("call_ret_same", PCResult, 32'h304);
    check_output("call_ret_depth", {31'b0, ras_empty}, 32'h0);
`else
    check_output("call_ret_same", PCResult, 32'h600);
`endif
    apply_stimulus(0, 32'h700, 0, 1);
`ifdef PC_SEQ_RAS_EN
    check_output("ret_replaced_top", PCResult, 32'h404);
    check_output("underflow_sticky", {31'b0, ras_underflow}, 32'h1);
`else
    check_output("ret_replaced_top", PCResult, 32'h700);
`endif

    apply_stimulus(1, 32'h40, 0, 0);
    clear_inputs(); halt = 1;
    tick();
    check_output("halt_pc", PCResult, 32'h40);
    check_output("halt_flag", {31'b0, halted}, 32'h1);
    apply_stimulus(1, 32'h80, 0, 0);
    check_output("halt_ignores_redirect", PCResult, 32'h40);
    check_output("still_halted", {31'b0, halted}, 32'h1);
    clear_inputs(); resume = 1;
    tick();
    check_output("resume_pc", PCResult, 32'h40);
    check_output("resume_flag", {31'b0, halted}, 32'h0);
    clear_inputs();
    tick(); check_output("after_resume", PCResult, 32'h44);
    halt = 1;
    tick(); check_output("halt_again", {31'b0, halted}, 32'h1);
    clear_inputs(); exc = 1;
    tick();
    check_output("exc_pc", PCResult, 32'h80);
    check_output("exc_unhalt", {31'b0, halted}, 32'h0);
    check_output("exc_clears_underflow", {31'b0, ras_underflow}, 32'h0);
    check_output("exc_empty", {31'b0, ras_empty}, 32'h1);
    clear_inputs();

    rst8 = 0;
    tick(); check_output("wrap8", {24'b0, pc8}, 32'h00);
    flush8 = 1;
    tick(); check_output("flush_at_zero8", {24'b0, pc8}, 32'hFC);
    flush8 = 0;
    tick(); check_output("wrap8_again", {24'b0, pc8}, 32'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
